// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - memory-game auto player: records leds symbols, replays them on chaves
// Optional build macro ERRO_INJ_EN adds inj_erro to corrupt the last replayed symbol.
module jogador_automatico #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 3,
    parameter int QUIET = 50
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ativar,
    input  logic [3:0]    leds,
    input  logic          acertou,
    input  logic          errou,
`ifdef ERRO_INJ_EN
    input  logic          inj_erro,
`endif
    output logic [3:0]    chaves,
    output logic          jogando,
    output logic          fim,
    output logic          overflow,
    output logic [AW:0]   db_tamanho,
    output logic [3:0]    db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        CAPTURA   = 4'd2,
        SILENCIO  = 4'd3,
        PRESSIONA = 4'd4,
        SOLTA     = 4'd5,
        FIM       = 4'd6
    } state_t;

    localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int QW   = $clog2(QUIET) + 1;

    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET - 1);
    localparam logic [QW-1:0] Q_ONE      = QW'(1);
    localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   C_ONE      = (AW + 1)'(1);
    localparam logic [AW-1:0] I_ONE      = AW'(1);

    state_t          state, state_n;
    logic [3:0]      leds_q;
    logic [AW:0]     count, count_n;
    logic            ovf, ovf_n;
    logic [AW-1:0]   idx, idx_n;
    logic [TW-1:0]   timer, timer_n;
    logic [QW-1:0]   quiet, quiet_n;
    logic [3:0]      chaves_r, chaves_n;
    logic            jog_r, fim_r;
    logic [3:0]      mem [DEPTH];

    logic            new_sym;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            last_idx;
    logic            next_is_last;
    logic [3:0]      replay_sym;

    // A direct change between two nonzero values is a new symbol too.
    assign new_sym      = (leds != 4'd0) && (leds != leds_q);
    assign last_idx     = ({1'b0, idx} == (count - C_ONE));
    assign next_is_last = ({1'b0, idx_n} == (count - C_ONE));

    always_comb begin
        replay_sym = mem[idx_n];
`ifdef ERRO_INJ_EN
        if (inj_erro && next_is_last) begin
            replay_sym = (mem[idx_n] == 4'd0) ? 4'b0001 : {mem[idx_n][2:0], mem[idx_n][3]};
        end
`endif
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        ovf_n    = ovf;
        idx_n    = idx;
        timer_n  = timer;
        quiet_n  = quiet;
        wr_en    = 1'b0;
        wr_addr  = count[AW-1:0];
        chaves_n = 4'd0;

        case (state)
            INICIAL, FIM: begin
                if (ativar) begin
                    state_n = ESPERA;
                    count_n = '0;
                    ovf_n   = 1'b0;
                end
            end
            ESPERA: begin
                if (new_sym) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    count_n = C_ONE;
                    state_n = CAPTURA;
                end
            end
            CAPTURA: begin
                if (leds == 4'd0) begin
                    state_n = SILENCIO;
                    quiet_n = '0;
                end else if (new_sym) begin
                    if (count == DEPTH_C) begin
                        ovf_n = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_n = count + C_ONE;
                    end
                end
            end
            SILENCIO: begin
                if (new_sym) begin
                    state_n = CAPTURA;
                    if (count == DEPTH_C) begin
                        ovf_n = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_n = count + C_ONE;
                    end
                end else if (quiet == QUIET_LAST) begin
                    state_n = PRESSIONA;
                    idx_n   = '0;
                    timer_n = '0;
                end else begin
                    quiet_n = quiet + Q_ONE;
                end
            end
            PRESSIONA: begin
                if (timer == HOLD_LAST) begin
                    state_n = SOLTA;
                    timer_n = '0;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            SOLTA: begin
                if (timer == GAP_LAST) begin
                    timer_n = '0;
                    if (last_idx) begin
                        state_n = ESPERA;
                        count_n = '0;
                    end else begin
                        idx_n   = idx + I_ONE;
                        state_n = PRESSIONA;
                    end
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            default: state_n = INICIAL;
        endcase

        // The game's verdict overrides everything while a round is in progress.
        if ((state != INICIAL) && (state != FIM) && (acertou || errou)) begin
            state_n = FIM;
            wr_en   = 1'b0;
        end

        if (state_n != PRESSIONA) begin
            chaves_n = 4'd0;
        end else if (state != PRESSIONA) begin
            chaves_n = replay_sym;
        end else begin
            chaves_n = chaves_r;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= INICIAL;
            leds_q   <= 4'd0;
            count    <= '0;
            ovf      <= 1'b0;
            idx      <= '0;
            timer    <= '0;
            quiet    <= '0;
            chaves_r <= 4'd0;
            jog_r    <= 1'b0;
            fim_r    <= 1'b0;
        end else begin
            state    <= state_n;
            leds_q   <= leds;
            count    <= count_n;
            ovf      <= ovf_n;
            idx      <= idx_n;
            timer    <= timer_n;
            quiet    <= quiet_n;
            chaves_r <= chaves_n;
            jog_r    <= (state_n != INICIAL) && (state_n != FIM);
            fim_r    <= (state_n == FIM);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 4'd0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= leds;
        end
    end

    assign chaves     = chaves_r;
    assign jogando    = jog_r;
    assign fim        = fim_r;
    assign overflow   = ovf;
    assign db_tamanho = count;
    assign db_estado  = state;

endmodule
